// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with run control.
// Matches a 1..8 bit pattern, counts hits, ends on stop or target count.
module seq_detect_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_pattern,
  input  logic [3:0] cfg_len,
  input  logic       cfg_overlap,
  input  logic [7:0] cfg_target,
  input  logic       x,
  input  logic       x_valid,
  output logic       busy,
  output logic       y,
  output logic [7:0] match_cnt,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] hist;
  logic [3:0] fill;
  logic [7:0] pat;
  logic [3:0] len;
  logic       ovl;
  logic [7:0] tgt;

  logic [7:0] hist_n;
  logic [3:0] fill_n;
  logic [7:0] mask;
  logic [7:0] cnt_n;
  logic       hit;
  logic       len_ok;

  assign busy   = (state == RUN);
  assign hist_n = {hist[6:0], x};
  assign fill_n = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
  // len is 1..8 once latched, so mask has len low ones
  assign mask   = ~(8'hFF << len);
  assign cnt_n  = (match_cnt == 8'hFF) ? 8'hFF
                : match_cnt + 8'd1;
  assign len_ok = (cfg_len != 4'd0) && (cfg_len <= 4'd8);
  assign hit    = x_valid && (fill_n >= len)
               && ((hist_n & mask) == (pat & mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      tgt       <= '0;
      y         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
    end else begin
      y    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            if (len_ok) begin
              pat       <= cfg_pattern;
              len       <= cfg_len;
              ovl       <= cfg_overlap;
              tgt       <= cfg_target;
              hist      <= '0;
              fill      <= '0;
              match_cnt <= '0;
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        (state == RUN): begin
          // stop wins over a coincident match
          if (stop) begin
            state <= IDLE;
          end else if (x_valid) begin
            hist <= hist_n;
            if (hit) begin
              y         <= 1'b1;
              match_cnt <= cnt_n;
              fill      <= ovl ? fill_n : 4'd0;
              if (tgt != 8'd0 && cnt_n == tgt) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              fill <= fill_n;
            end
          end
        end
        (state == DONE): begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl.
// Expected y/done/err events are queued by the driver, popped by a monitor.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       y;
  logic [7:0] match_cnt;
  logic       done;
  logic       err;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .x           (x),
    .x_valid     (x_valid),
    .busy        (busy),
    .y           (y),
    .match_cnt   (match_cnt),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  localparam int EV_Y    = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop_ev(input int kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind %0d at cycle %0d",
               kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cnt != int'(match_cnt)) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d cnt %0d expected kind %0d cyc %0d cnt %0d",
                 kind, cyc, match_cnt, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (y)    pop_ev(EV_Y);
    if (done) pop_ev(EV_DONE);
    if (err)  pop_ev(EV_ERR);
  end

  task automatic push(input int kind, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l,
                          input logic o, input logic [7:0] t,
                          input bit exp_err);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_target  = t;
    start       = 1'b1;
    if (exp_err) push(EV_ERR, int'(match_cnt));
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b, input bit exp_y, input int ecnt,
                      input bit exp_done);
    x       = b;
    x_valid = 1'b1;
    if (exp_y)    push(EV_Y, ecnt);
    if (exp_done) push(EV_DONE, ecnt);
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " y"}, int'(y), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " err"}, int'(err), 0);
    chk({nm, " cnt"}, int'(match_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_overlap = 1'b0;
    cfg_target = '0;
    x = 1'b0;
    x_valid = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // overlapping 1011 in 1,0,1,1,0,1,1
    do_start(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
    chk("ovl busy", int'(busy), 1);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 1, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 2, 0);
    chk("ovl cnt", int'(match_cnt), 2);
    do_stop();
    chk("ovl stop busy", int'(busy), 0);
    chk("ovl hold cnt", int'(match_cnt), 2);

    // non-overlapping: fill cleared after first hit
    do_start(8'h0B, 4'd4, 1'b0, 8'd0, 1'b0);
    chk("novl start cnt", int'(match_cnt), 0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 1, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    chk("novl cnt", int'(match_cnt), 1);
    do_stop();

    // target 2 ends the run
    do_start(8'h0B, 4'd4, 1'b1, 8'd2, 1'b0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 1, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 1, 2, 1);
    chk("tgt busy in done", int'(busy), 0);
    tick();
    chk("tgt busy after", int'(busy), 0);
    chk("tgt cnt", int'(match_cnt), 2);
    chk("tgt done clear", int'(done), 0);

    // gaps of x_valid=0, plus a start ignored in RUN
    do_start(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
    send(1, 0, 0, 0);
    tick(); tick(); tick();
    send(0, 0, 0, 0);
    cfg_len = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    send(1, 0, 0, 0);
    tick(); tick(); tick();
    send(1, 1, 1, 0);
    tick(); tick(); tick();
    chk("gap cnt", int'(match_cnt), 1);
    chk("gap busy", int'(busy), 1);
    do_stop();

    // illegal lengths
    do_start(8'h0B, 4'd9, 1'b1, 8'd0, 1'b1);
    chk("len9 busy", int'(busy), 0);
    tick();
    chk("len9 err one cycle", int'(err), 0);
    do_start(8'h0B, 4'd0, 1'b1, 8'd0, 1'b1);
    chk("len0 busy", int'(busy), 0);
    tick();

    // reset mid-run clears history
    do_start(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_reset("midrun rst");
    rst = 1'b0;
    tick();
    do_start(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
    send(1, 0, 0, 0);
    send(0, 0, 0, 0);
    send(1, 0, 0, 0);
    // stop with the completing bit discards the match
    x = 1'b1;
    x_valid = 1'b1;
    stop = 1'b1;
    tick();
    x_valid = 1'b0;
    stop = 1'b0;
    tick();
    chk("stop cnt", int'(match_cnt), 0);
    chk("stop busy", int'(busy), 0);
    chk("stop y", int'(y), 0);

    tick(); tick();
    chk("queue empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  single-cycle request to latch the configuration and begin a detection run.
REQ-005 stop  input  1  single-cycle abort of the active run.
REQ-006 cfg_pattern  input  8  target pattern, right-justified; bit [len-1] is the first bit received.
REQ-007 cfg_len  input  4  pattern length; the legal range is 1..8.
REQ-008 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history is cleared after each match.
REQ-009 cfg_target  input  8  match count that ends the run; 0 = run until stop.
REQ-010 x  input  1  serial data bit.
REQ-011 x_valid  input  1  x is sampled only on edges where x_valid=1.
REQ-012 busy  output  1  high while in state RUN.
REQ-013 y  output  1  registered match pulse, one cycle wide.
REQ-014 match_cnt  output  8  matches counted in the current run; saturates at 255.
REQ-015 done  output  1  one-cycle pulse when the target count is reached.
REQ-016 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE, encoded as 2 bits.
REQ-018 In IDLE, start=1 with a legal cfg_len SHALL latch cfg_pattern, cfg_len, cfg_overlap and cfg_target.
  - On that same edge it SHALL clear the 8-bit history register, the fill counter and match_cnt.
  - The FSM SHALL then enter RUN.
REQ-019 In IDLE, start=1 with cfg_len=0 or cfg_len>8 SHALL assert err on the next cycle for one cycle, and the FSM SHALL remain in IDLE.
REQ-020 In RUN, start SHALL be ignored.
  - Configuration input changes SHALL have no effect until the next accepted start.
REQ-021 In RUN, on each edge with x_valid=1, the history SHALL become {hist[6:0], x}.
  - The fill counter SHALL increment, saturating at 8.
REQ-022 A match SHALL occur on an edge when both conditions hold:
  - x_valid=1;
  - the updated fill is >= len and the updated hist[len-1:0] equals pattern[len-1:0].
REQ-023 A match SHALL register y=1 in the following cycle only; y SHALL otherwise be 0.
  - Latency is 1 cycle from sampling the final pattern bit.
REQ-024 A match SHALL increment match_cnt on the same edge that sets y.
  - match_cnt SHALL hold at 255 when saturated.
REQ-025 When cfg_overlap=0, a match SHALL clear the fill counter to 0 on the same edge, so the next match needs len fresh bits.
  - When cfg_overlap=1, fill SHALL be kept.
REQ-026 Edges with x_valid=0 SHALL leave the history, fill, y and match_cnt unchanged, except that y is still cleared after its one cycle.
REQ-027 When cfg_target!=0 and a match makes match_cnt equal to cfg_target, the FSM SHALL enter DONE on that edge.
REQ-028 DONE SHALL last exactly one cycle, with done=1; the FSM SHALL then return to IDLE.
  - match_cnt SHALL hold its value until the next accepted start.
REQ-029 stop=1 in RUN SHALL return the FSM to IDLE on that edge with no done pulse.
  - A match on that same edge SHALL be discarded: no y and no count.
  - stop SHALL be ignored in IDLE and DONE.
REQ-030 busy SHALL be combinationally equal to (state==RUN).
  - y, done and err SHALL be registered.

Reset
REQ-031 rst=1 SHALL force the FSM to IDLE and clear history, fill, the latched configuration, y, done, err and match_cnt on the same edge.
REQ-032 rst SHALL take priority over start, stop and x_valid.
  - Reset mid-run SHALL abort with no done pulse.
REQ-033 Outputs SHALL be busy=0, y=0, done=0, err=0 and match_cnt=0 from the first edge after rst is asserted.

Verification
REQ-034 pattern=4'b1011, len=4, overlap=1, target=0, x_valid=1, x=1,0,1,1,0,1,1 -> y pulses after the 4th and 7th bits; match_cnt=2.
REQ-035 The same stream with overlap=0 -> a single y pulse after the 4th bit; match_cnt=1.
REQ-036 Overlap=1, target=2, same stream -> done pulses in the cycle after the 7th bit; busy=0 the following cycle; match_cnt stays 2.
REQ-037 Stream 1,0,1,1 with x_valid=0 for 3 cycles between each bit -> exactly one y pulse, one cycle after the last valid bit.
REQ-038 start with cfg_len=9 -> err=1 for one cycle; busy stays 0.
  - start with cfg_len=0 -> the same response.
REQ-039 rst asserted mid-run after bits 1,0,1 of pattern 1011, then a restart and input 1 -> no y pulse, because the history was cleared.
  - A stop pulse on the edge of the 4th bit -> no y pulse and match_cnt=0.
